// File: rtl/fp16_result_packer_if.sv
// Handshake/data bundle between the operand controller, the result packer and result memory.
// The controller side is the master; the packer side is the slave.
interface fp16_result_packer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              sinal_in;
    logic [4:0]        expoente_in;
    logic [11:0]       mantissa_in;
    logic              busy;
    logic              done;
    logic              hab_Escrita;
    logic [ADDR_W-1:0] endereco_Escrita;
    logic [15:0]       resultado;
    logic              overflow;
    logic              underflow;

    modport master (
        output start, sinal_in, expoente_in, mantissa_in,
        input  busy, done, hab_Escrita, endereco_Escrita, resultado, overflow, underflow
    );

    modport slave (
        input  start, sinal_in, expoente_in, mantissa_in,
        output busy, done, hab_Escrita, endereco_Escrita, resultado, overflow, underflow
    );
endinterface

// File: rtl/fp16_result_packer.sv
// Normalises, rounds (nearest-even, guard bit only) and packs an FP16 adder result, then writes it out.
// Latency 3 + shift cycles (2 for zero/inf-input/immediate flush); no backpressure: start is ignored while busy.
module fp16_result_packer #(
    parameter int ADDR_W  = 8,
    parameter int EXP_MAX = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    fp16_result_packer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, WRITE} state_t;

    localparam logic [5:0] EMAX = 6'(EXP_MAX);

    state_t            state_q, state_d;
    logic              s_q, s_d;
    logic [5:0]        e_q, e_d;
    logic [11:0]       m_q, m_d;
    logic              g_q, g_d;
    logic              first_q, first_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       res_q, res_d;
    logic              ov_q, ov_d;
    logic              uf_q, uf_d;
    logic [11:0]       m_rnd;
    logic [5:0]        e_rnd;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        e_d     = e_q;
        m_d     = m_q;
        g_d     = g_q;
        first_d = first_q;
        addr_d  = addr_q;
        res_d   = res_q;
        ov_d    = ov_q;
        uf_d    = uf_q;
        m_rnd   = m_q + {11'd0, g_q & m_q[0]};
        e_rnd   = e_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    s_d     = bus.sinal_in;
                    e_d     = {1'b0, bus.expoente_in};
                    m_d     = bus.mantissa_in;
                    g_d     = 1'b0;
                    first_d = 1'b1;
                    state_d = NORM;
                end
            end
            NORM: begin
                first_d = 1'b0;
                // An all-ones exponent only means an infinite operand on the first NORM cycle;
                // reaching it later through a right shift is caught by ROUND instead.
                if (m_q == 12'd0) begin
                    res_d   = 16'h0000;
                    ov_d    = 1'b0;
                    uf_d    = 1'b0;
                    state_d = WRITE;
                end else if (first_q && (e_q == EMAX)) begin
                    res_d   = {s_q, EMAX[4:0], 10'h000};
                    ov_d    = 1'b1;
                    uf_d    = 1'b0;
                    state_d = WRITE;
                end else if (m_q[11]) begin
                    g_d = m_q[0];
                    m_d = m_q >> 1;
                    e_d = e_q + 6'd1;
                end else if (!m_q[10] && (e_q > 6'd1)) begin
                    m_d = m_q << 1;
                    e_d = e_q - 6'd1;
                end else if (!m_q[10]) begin
                    res_d   = {s_q, 15'h0000};
                    ov_d    = 1'b0;
                    uf_d    = 1'b1;
                    state_d = WRITE;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (m_rnd[11]) begin
                    m_rnd = m_rnd >> 1;
                    e_rnd = e_q + 6'd1;
                end
                if (e_rnd >= EMAX) begin
                    res_d = {s_q, EMAX[4:0], 10'h000};
                    ov_d  = 1'b1;
                end else begin
                    res_d = {s_q, e_rnd[4:0], m_rnd[9:0]};
                    ov_d  = 1'b0;
                end
                uf_d    = 1'b0;
                state_d = WRITE;
            end
            WRITE: begin
                addr_d  = addr_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == WRITE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            e_q     <= 6'd0;
            m_q     <= 12'd0;
            g_q     <= 1'b0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            res_q   <= 16'h0000;
            ov_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            e_q     <= e_d;
            m_q     <= m_d;
            g_q     <= g_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            res_q   <= res_d;
            ov_q    <= ov_d;
            uf_q    <= uf_d;
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.hab_Escrita      = done_q;
    assign bus.endereco_Escrita = addr_q;
    assign bus.resultado        = res_q;
    assign bus.overflow         = ov_q;
    assign bus.underflow        = uf_q;
endmodule

// File: doc/fp16_result_packer.md
Name: fp16_result_packer

Overview:
- Write-side counterpart of the FP16 operand-unpack controller.
- Takes the raw adder output (sign, exponent, 12-bit mantissa sum with carry bit) and normalises it iteratively, rounds it, and packs it into an IEEE-754 half-precision word.
- Writes that word to the result memory at an auto-incrementing address, then pulses `done` back to the controller.

Parameters:
- ADDR_W, 8, width of the result-memory address counter.
- EXP_MAX, 31, all-ones exponent; reaching it means infinity/overflow.

Ports:
- clock  input  1  system clock; everything updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- sinal_in  input  1  result sign.
- expoente_in  input  5  exponent of the aligned operands (biased 15).
- mantissa_in  input  12  unsigned mantissa sum; bit 11 = carry, bit 10 = hidden 1.
- busy  output  1  high from the cycle after `start` is accepted until the WRITE cycle, inclusive.
- done  output  1  one-cycle pulse in the WRITE cycle.
- hab_Escrita  output  1  result-memory write enable; one-cycle pulse coincident with `done`.
- endereco_Escrita  output  ADDR_W  write address.
- resultado  output  16  packed FP16 word {sign, exp[4:0], frac[9:0]}; valid while `done`=1.
- overflow  output  1  sticky per result; set with `done` when the result is infinity.
- underflow  output  1  sticky per result; set with `done` when the result is flushed to zero.

Behaviour:
- Reset:
  - state=IDLE; busy, done, hab_Escrita, overflow, underflow all 0.
  - resultado=16'h0000; endereco_Escrita=0.
  - Reset in any state aborts the operation with no memory write.
- All outputs are registered.
- FSM states: IDLE, NORM, ROUND, WRITE.
- IDLE:
  - On start=1, latch sinal_in, expoente_in, mantissa_in into internal regs s, e(6-bit), m(12-bit); clear guard g; go to NORM.
  - `start` while not IDLE is ignored; there is no queue.
- NORM: evaluate in this priority order, one action per cycle.
  - (a) m==0: result 16'h0000 (positive zero), flags 0, go to WRITE.
  - (b) e==31 at entry: force infinity {s,5'h1F,10'h000}, overflow=1, go to WRITE.
  - (c) m[11]==1: g=m[0], m=m>>1, e=e+1; stay in NORM.
  - (d) m[10]==0 and e>1: m=m<<1, e=e-1; stay in NORM.
  - (e) m[10]==0 and e<=1: flush to {s,15'h0}, underflow=1, go to WRITE.
  - (f) otherwise (normalised): go to ROUND.
- ROUND:
  - Round to nearest, ties-to-even with a guard bit only: if g==1 and m[0]==1, m=m+1.
  - If m[11] becomes 1 after rounding: m=m>>1, e=e+1.
  - If e>=31: result infinity {s,5'h1F,0}, overflow=1.
  - Else resultado={s,e[4:0],m[9:0]}.
  - Go to WRITE.
- WRITE:
  - done=1 and hab_Escrita=1 for exactly this cycle; endereco_Escrita holds the address being written.
  - On exit, endereco_Escrita increments, wrapping 255->0.
  - Go to IDLE; busy drops the next cycle.
- resultado and the flags hold their last value until the next WRITE.
- Latency from the `start` edge to the `done` cycle:
  - Normal results: 3 + number of NORM shift cycles. Best case is 3; no-shift and single-right-shift cases give 3 or 4.
  - Zero, infinity-input and flush results skip ROUND.
- Back-to-back: `start` may be asserted in the cycle after `done` (IDLE) and is accepted.

Test Plan:
- 1.0+1.0: s=0, e=15, m=12'h800, start -> one right shift; done 4 cycles after start; resultado=16'h4000; hab_Escrita at addr 0; addr becomes 1.
- Cancellation: e=15, m=12'h001 -> 10 left shifts, e=5; resultado=16'h1400; done 13 cycles after start.
- Round carry: s=0, e=15, m=12'hFFF -> right shift gives g=1, m[0]=1; round gives 0x800; renormalise to e=17; resultado=16'h4400, overflow=0.
- Overflow: e=30, m=12'h800 -> e=31; resultado=16'h7C00, overflow=1. Separately, s=1, e=31 input -> 16'hFC00.
- Underflow and zero:
  - e=2, m=12'h001 -> e reaches 1 with m[10]=0; resultado=16'h0000, underflow=1.
  - m=0 -> 16'h0000, flags 0.
- Control:
  - 256 consecutive ops -> address wraps 255->0.
  - `start` pulsed during NORM -> ignored.
  - Reset asserted mid-NORM -> no hab_Escrita, address=0, state IDLE next cycle.
